// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, functs,
// ALU and mux select codes, state encoding and the per-state Moore decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_JUMP    = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  // Moore outputs of a state; fields not set stay 0.
  function automatic ctrl_t ctrl_for(state_t s, logic [3:0] r_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.src_b = SRCB_FOUR; c.alu_ctrl = ALU_ADD; c.pc_src = PCSRC_ALU; end
      S_DECODE:  begin c.src_b = SRCB_IMM_SH; c.alu_ctrl = ALU_ADD; end
      S_MEMADR:  begin c.src_a = 1'b1; c.src_b = SRCB_IMM; c.alu_ctrl = ALU_ADD; end
      S_MEMRD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC_R:  begin c.src_a = 1'b1; c.src_b = SRCB_B; c.alu_ctrl = r_alu; end
      S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:  begin c.src_a = 1'b1; c.src_b = SRCB_B; c.alu_ctrl = ALU_SUB; c.pc_src = PCSRC_ALUOUT; end
      S_ADDI_EX: begin c.src_a = 1'b1; c.src_b = SRCB_IMM; c.alu_ctrl = ALU_ADD; end
      S_ADDI_WB: begin c.reg_write = 1'b1; end
      S_JUMP:    begin c.pc_src = PCSRC_JUMP; c.pc_write = 1'b1; end
      S_HALT:    begin c.halted = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Maps an R-type funct field to the ALU operation and flags unsupported functs.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       funct_valid
);

  // funct -> ALU op lookup
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with ready-handshaked memory and a bounded
// wait timeout; Moore outputs are registered, fetch/branch enables are Mealy.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       IorD_Sel,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       RegDst_Sel,
  output logic       MemToReg_Sel,
  output logic       Reg_Write,
  output logic       ALUSrcA_Sel,
  output logic [1:0] ALUSrcB_Sel,
  output logic [3:0] ALU_Ctrl,
  output logic [1:0] PCSrc_Sel,
  output logic       Illegal_Op,
  output logic       Bus_Error,
  output logic       Halted,
  output logic [3:0] State
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_r, state_n;
  ctrl_t            ctrl_r, ctrl_n;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             illegal_r, bus_err_r;
  logic [3:0]       funct_alu_s;
  logic             funct_valid_s;
  logic             mem_wait_s, timeout_s, illegal_s, fetch_done_s;

  mips_alu_decode u_alu_decode (
    .funct       (Funct),
    .alu_ctrl    (funct_alu_s),
    .funct_valid (funct_valid_s)
  );

  // A timeout fires on the wait cycle that would bring the counter to the limit.
  assign mem_wait_s   = is_wait_state(state_r) && !Mem_Ready;
  assign timeout_s    = (MEM_TIMEOUT > 0) && mem_wait_s && (wait_cnt_r == TIMEOUT_LAST);
  assign illegal_s    = (state_r == S_DECODE) && (state_n == S_HALT);
  assign fetch_done_s = (state_r == S_FETCH) && Mem_Ready;

  // Next-state selection
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:    state_n = S_FETCH;
      S_FETCH:   state_n = timeout_s ? S_HALT : (Mem_Ready ? S_DECODE : S_FETCH);
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = funct_valid_s ? S_EXEC_R : S_HALT;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDI_EX;
          OP_J:         state_n = S_JUMP;
          default:      state_n = S_HALT;
        endcase
      end
      S_MEMADR:  state_n = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_n = timeout_s ? S_HALT : (Mem_Ready ? S_MEMWB : S_MEMRD);
      S_MEMWB:   state_n = S_FETCH;
      S_MEMWR:   state_n = timeout_s ? S_HALT : (Mem_Ready ? S_FETCH : S_MEMWR);
      S_EXEC_R:  state_n = S_ALUWB;
      S_ALUWB:   state_n = S_FETCH;
      S_BRANCH:  state_n = S_FETCH;
      S_ADDI_EX: state_n = S_ADDI_WB;
      S_ADDI_WB: state_n = S_FETCH;
      S_JUMP:    state_n = S_FETCH;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_HALT;
    endcase
  end

  // Moore outputs for the state being entered, so they register with it
  always_comb begin
    ctrl_n = ctrl_for(state_n, funct_alu_s);
  end

  // State, registered outputs, wait counter and sticky error flags
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= S_IDLE;
      ctrl_r     <= '0;
      wait_cnt_r <= '0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      state_r   <= state_n;
      ctrl_r    <= ctrl_n;
      illegal_r <= illegal_r | illegal_s;
      bus_err_r <= bus_err_r | timeout_s;
      if (state_n != state_r) begin
        wait_cnt_r <= '0;
      end else if (mem_wait_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  assign IR_Write     = fetch_done_s;
  assign PC_Write     = ctrl_r.pc_write | fetch_done_s | ((state_r == S_BRANCH) && Zero);
  assign IorD_Sel     = ctrl_r.iord;
  assign Mem_Read     = ctrl_r.mem_read;
  assign Mem_Write    = ctrl_r.mem_write;
  assign RegDst_Sel   = ctrl_r.reg_dst;
  assign MemToReg_Sel = ctrl_r.mem_to_reg;
  assign Reg_Write    = ctrl_r.reg_write;
  assign ALUSrcA_Sel  = ctrl_r.src_a;
  assign ALUSrcB_Sel  = ctrl_r.src_b;
  assign ALU_Ctrl     = ctrl_r.alu_ctrl;
  assign PCSrc_Sel    = ctrl_r.pc_src;
  assign Halted       = ctrl_r.halted;
  assign Illegal_Op   = illegal_r;
  assign Bus_Error    = bus_err_r;
  assign State        = state_r;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed scenarios then random
// instruction streams, each cycle compared against an instruction-level model.
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam int T = 4;

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic [1:0] pc_src;
    logic       illegal, bus_err, halted;
    logic [3:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, iord_sel, mem_read, mem_write, ir_write;
  logic       regdst_sel, memtoreg_sel, reg_write, alusrca_sel;
  logic [1:0] alusrcb_sel, pcsrc_sel;
  logic [3:0] alu_ctrl, state;
  logic       illegal_op, bus_error, halted;
  obs_t       obs;

  int n_cmp = 0;
  int n_err = 0;
  logic ill_m = 1'b0;
  logic be_m  = 1'b0;

  logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  mips_mc_control #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .Mem_Ready(mem_ready), .PC_Write(pc_write), .IorD_Sel(iord_sel),
    .Mem_Read(mem_read), .Mem_Write(mem_write), .IR_Write(ir_write),
    .RegDst_Sel(regdst_sel), .MemToReg_Sel(memtoreg_sel), .Reg_Write(reg_write),
    .ALUSrcA_Sel(alusrca_sel), .ALUSrcB_Sel(alusrcb_sel), .ALU_Ctrl(alu_ctrl),
    .PCSrc_Sel(pcsrc_sel), .Illegal_Op(illegal_op), .Bus_Error(bus_error),
    .Halted(halted), .State(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, iord_sel, mem_read, mem_write, ir_write,
                regdst_sel, memtoreg_sel, reg_write, alusrca_sel,
                alusrcb_sel, alu_ctrl, pcsrc_sel,
                illegal_op, bus_error, halted, state};

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic obs_t blank(logic [3:0] st);
    obs_t o;
    o = '0;
    o.state   = st;
    o.illegal = ill_m;
    o.bus_err = be_m;
    return o;
  endfunction

  function automatic bit legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h23, 6'h2B, 6'h04, 6'h08, 6'h02: return 1'b1;
      6'h00: return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Drive one cycle's inputs at the falling edge, check, move to the next falling edge.
  task automatic step(input logic rdy, input logic z, input obs_t e, input string tag);
    mem_ready = rdy;
    zero      = z;
    #1;
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic halt_cycles(input int n);
    obs_t h;
    h = blank(S_HALT);
    h.halted = 1'b1;
    for (int i = 0; i < n; i++) step(1'(i), rbit(), h, "halt");
  endtask

  task automatic mem_phase(input logic [3:0] st, input int waits, output bit to);
    obs_t e, done;
    e = blank(st);
    if (st == S_FETCH) begin
      e.mem_read = 1'b1; e.src_b = 2'b01; e.alu = 4'b0010;
    end else if (st == S_MEMRD) begin
      e.iord = 1'b1; e.mem_read = 1'b1;
    end else begin
      e.iord = 1'b1; e.mem_write = 1'b1;
    end
    to = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step(1'b0, rbit(), e, "mem_wait");
      if (i + 1 == T) begin
        to = 1'b1;
        break;
      end
    end
    if (to) begin
      be_m = 1'b1;
      halt_cycles(3);
    end else begin
      done = e;
      if (st == S_FETCH) begin
        done.ir_write = 1'b1; done.pc_write = 1'b1;
      end
      step(1'b1, rbit(), done, "mem_done");
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, output bit hlt);
    obs_t e;
    bit to;
    opcode = op;
    funct  = fn;
    hlt    = 1'b0;
    mem_phase(S_FETCH, wf, to);
    if (to) begin
      hlt = 1'b1;
      return;
    end
    e = blank(S_DECODE); e.src_b = 2'b11; e.alu = 4'b0010;
    step(rbit(), rbit(), e, "decode");
    if (!legal(op, fn)) begin
      ill_m = 1'b1;
      halt_cycles(4);
      hlt = 1'b1;
      return;
    end
    case (op)
      6'h00: begin
        e = blank(S_EXEC_R); e.src_a = 1'b1; e.alu = alu_of(fn);
        step(rbit(), rbit(), e, "exec_r");
        e = blank(S_ALUWB); e.reg_dst = 1'b1; e.reg_write = 1'b1;
        step(rbit(), rbit(), e, "aluwb");
      end
      6'h23, 6'h2B: begin
        e = blank(S_MEMADR); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0010;
        step(rbit(), rbit(), e, "memadr");
        mem_phase((op == 6'h23) ? S_MEMRD : S_MEMWR, wm, to);
        if (to) begin
          hlt = 1'b1;
        end else if (op == 6'h23) begin
          e = blank(S_MEMWB); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
          step(rbit(), rbit(), e, "memwb");
        end
      end
      6'h04: begin
        e = blank(S_BRANCH); e.src_a = 1'b1; e.alu = 4'b0110; e.pc_src = 2'b01; e.pc_write = z;
        step(rbit(), z, e, "branch");
      end
      6'h08: begin
        e = blank(S_ADDI_EX); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0010;
        step(rbit(), rbit(), e, "addi_ex");
        e = blank(S_ADDI_WB); e.reg_write = 1'b1;
        step(rbit(), rbit(), e, "addi_wb");
      end
      default: begin
        e = blank(S_JUMP); e.pc_src = 2'b10; e.pc_write = 1'b1;
        step(rbit(), rbit(), e, "jump");
      end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ill_m = 1'b0;
    be_m  = 1'b0;
    step(rbit(), rbit(), blank(S_IDLE), "reset");
    rst_n = 1'b1;
    step(rbit(), rbit(), blank(S_IDLE), "idle_after_reset");
  endtask

  initial begin
    obs_t e;
    bit hlt;
    logic [5:0] op, fn;
    int wf, wm;

    @(negedge clk);
    do_reset();

    // Directed: R add, lw with 3 waits, beq taken/not taken, fetch ready on 4th cycle
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, hlt);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, hlt);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, hlt);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, hlt);
    run_instr(6'h2B, 6'h00, 1'b0, T - 1, 3, hlt);
    run_instr(6'h02, 6'h00, 1'b0, 1, 0, hlt);
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, hlt);

    // Reset asserted mid-MEMWR while Mem_Write is high
    opcode = 6'h2B;
    mem_phase(S_FETCH, 0, hlt);
    e = blank(S_DECODE); e.src_b = 2'b11; e.alu = 4'b0010;
    step(1'b0, 1'b0, e, "decode");
    e = blank(S_MEMADR); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0010;
    step(1'b0, 1'b0, e, "memadr");
    e = blank(S_MEMWR); e.iord = 1'b1; e.mem_write = 1'b1;
    step(1'b0, 1'b0, e, "memwr_before_reset");
    #2 rst_n = 1'b0;
    step(1'b0, 1'b0, blank(S_IDLE), "reset_mid_memwr");
    rst_n = 1'b1;
    step(1'b1, 1'b0, blank(S_IDLE), "idle_after_reset");

    // Illegal opcode and illegal funct
    run_instr(6'h3F, 6'h20, 1'b0, 0, 0, hlt);
    do_reset();
    run_instr(6'h00, 6'h03, 1'b0, 0, 0, hlt);
    do_reset();

    // Fetch timeout, then MEMRD timeout
    run_instr(6'h00, 6'h20, 1'b0, T + 2, 0, hlt);
    do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 0, T + 1, hlt);
    do_reset();

    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 5)];
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      wf = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
      wm = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
      run_instr(op, fn, rbit(), wf, wm, hlt);
      if (hlt) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
